// File: rtl/adc_temp_sampler.sv
// Periodic ADC conversion sequencer with averaging and open/short/timeout fault detection.
// One request per sample period; 2^AVG_LOG2 good samples are averaged into temp_code.
module adc_temp_sampler #(
  parameter int          SAMPLE_DIV   = 10000,
  parameter int          AVG_LOG2     = 3,
  parameter logic [2:0]  ADC_CHANNEL  = 3'd0,
  parameter int          TIMEOUT_CYC  = 400,
  parameter logic [11:0] OPEN_THRESH  = 12'hFF0,
  parameter logic [11:0] SHORT_THRESH = 12'h00F,
  parameter int          FAULT_CNT    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fault_clr,
  output logic        adc_start,
  output logic [2:0]  adc_channel,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  output logic [11:0] temp_code,
  output logic        temp_valid,
  output logic        sensor_open,
  output logic        sensor_short,
  output logic        adc_timeout
);

  localparam int DATA_W = 12;
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int SC_W   = AVG_LOG2 + 1;
  localparam int FC_W   = $clog2(FAULT_CNT + 1);

  localparam logic [15:0]     DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [SC_W-1:0] N_AVG    = SC_W'(1 << AVG_LOG2);
  localparam logic [FC_W-1:0] FC_MAX   = FC_W'(FAULT_CNT);

  typedef enum logic [1:0] {IDLE, WAIT_TICK, START, WAIT_DATA} state_t;

  function automatic logic [FC_W-1:0] run_inc(input logic [FC_W-1:0] c);
    return (c >= FC_MAX) ? FC_MAX : c + 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] s);
    return DATA_W'(s >> AVG_LOG2);
  endfunction

  state_t              state, state_nx;
  logic [15:0]         period_cnt;
  logic [15:0]         to_cnt;
  logic                tick;
  logic                timeout_hit;
  logic [ACC_W-1:0]    acc;
  logic [SC_W-1:0]     sample_cnt;
  logic [FC_W-1:0]     open_run, short_run;

  logic                vld_p0;
  logic [DATA_W-1:0]   data_p0;
  logic                is_open, is_short;
  logic [ACC_W-1:0]    acc_nx;
  logic [SC_W-1:0]     cnt_nx;
  logic [FC_W-1:0]     open_nx, short_nx;

  assign adc_channel = ADC_CHANNEL;
  assign tick        = enable && (period_cnt == DIV_LAST);

  // Sample qualification: only results arriving while a conversion is outstanding count.
  assign vld_p0      = enable && adc_valid && (state == WAIT_DATA);
  assign data_p0     = adc_data;
  assign timeout_hit = enable && !adc_valid && (state == WAIT_DATA) && (to_cnt == TO_LAST);
  assign is_open     = data_p0 >= OPEN_THRESH;
  assign is_short    = data_p0 <= SHORT_THRESH;
  assign acc_nx      = acc + ACC_W'(data_p0);
  assign cnt_nx      = sample_cnt + 1'b1;
  assign open_nx     = run_inc(open_run);
  assign short_nx    = run_inc(short_run);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:      state_nx = WAIT_TICK;
        WAIT_TICK: if (tick) state_nx = START;
        START:     state_nx = WAIT_DATA;
        WAIT_DATA: if (adc_valid || timeout_hit) state_nx = WAIT_TICK;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // adc_start is registered so it is high exactly while the FSM sits in START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_start <= 1'b0;
    end else begin
      adc_start <= (state_nx == START);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      if (!enable || period_cnt == DIV_LAST) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 1'b1;
      end
      if (state == START) begin
        to_cnt <= '0;
      end else if (state == WAIT_DATA) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Accumulate / classify stage: result and flags visible the cycle after adc_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      sample_cnt   <= '0;
      open_run     <= '0;
      short_run    <= '0;
      temp_code    <= '0;
      temp_valid   <= 1'b0;
      sensor_open  <= 1'b0;
      sensor_short <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      if (!enable) begin
        acc        <= '0;
        sample_cnt <= '0;
        open_run   <= '0;
        short_run  <= '0;
      end else if (timeout_hit) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else if (vld_p0) begin
        if (is_open) begin
          open_run  <= open_nx;
          short_run <= '0;
          if (open_nx == FC_MAX) sensor_open <= 1'b1;
        end else if (is_short) begin
          short_run <= short_nx;
          open_run  <= '0;
          if (short_nx == FC_MAX) sensor_short <= 1'b1;
        end else begin
          open_run     <= '0;
          short_run    <= '0;
          sensor_open  <= 1'b0;
          sensor_short <= 1'b0;
          if (cnt_nx == N_AVG) begin
            temp_code  <= avg_trunc(acc_nx);
            temp_valid <= 1'b1;
            acc        <= '0;
            sample_cnt <= '0;
          end else begin
            acc        <= acc_nx;
            sample_cnt <= cnt_nx;
          end
        end
      end
    end
  end

  // A timeout in the same cycle as fault_clr must stay visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_timeout <= 1'b0;
    end else if (timeout_hit) begin
      adc_timeout <= 1'b1;
    end else if (fault_clr) begin
      adc_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_temp_sampler.sv
// Bench for adc_temp_sampler: directed vector table, timeout/enable/reset sequences,
// and randomized conversions checked against a sample-level reference model.
module tb_adc_temp_sampler;

  localparam int SD = 20;
  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        rst_n, enable, fault_clr, adc_valid;
  logic [11:0] adc_data;
  logic        adc_start, temp_valid, sensor_open, sensor_short, adc_timeout;
  logic [2:0]  adc_channel;
  logic [11:0] temp_code;

  adc_temp_sampler #(
    .SAMPLE_DIV(SD), .AVG_LOG2(3), .ADC_CHANNEL(3'd0), .TIMEOUT_CYC(TO),
    .OPEN_THRESH(12'hFF0), .SHORT_THRESH(12'h00F), .FAULT_CNT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault_clr(fault_clr),
    .adc_start(adc_start), .adc_channel(adc_channel), .adc_data(adc_data),
    .adc_valid(adc_valid), .temp_code(temp_code), .temp_valid(temp_valid),
    .sensor_open(sensor_open), .sensor_short(sensor_short), .adc_timeout(adc_timeout)
  );

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int en_cyc;

  // Reference model state: samples collected since the last clear, fault runs, outputs.
  int          m_sum, m_n, m_orun, m_srun;
  logic        m_open, m_short, m_tmo;
  logic [11:0] m_code;

  typedef struct {
    logic [11:0] d;
    logic        tv;
    logic [11:0] code;
    logic        op;
    logic        sh;
  } vec_t;
  vec_t tbl[40];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sum = 0; m_n = 0; m_orun = 0; m_srun = 0;
    m_open = 0; m_short = 0; m_tmo = 0; m_code = 12'h000;
  endtask

  task automatic model_sample(input logic [11:0] d, output logic tv);
    tv = 1'b0;
    if (d >= 12'hFF0) begin
      m_orun = (m_orun < 3) ? m_orun + 1 : 3;
      m_srun = 0;
      if (m_orun == 3) m_open = 1'b1;
    end else if (d <= 12'h00F) begin
      m_srun = (m_srun < 3) ? m_srun + 1 : 3;
      m_orun = 0;
      if (m_srun == 3) m_short = 1'b1;
    end else begin
      m_orun = 0; m_srun = 0; m_open = 1'b0; m_short = 1'b0;
      m_sum += int'(d);
      m_n++;
      if (m_n == 8) begin
        m_code = 12'(m_sum / 8);
        tv = 1'b1;
        m_sum = 0;
        m_n = 0;
      end
    end
  endtask

  task automatic wait_start(output int s);
    for (int k = 0; k < 100; k++) begin
      if (adc_start) break;
      step();
    end
    chk("start_seen", 32'(adc_start), 32'(1));
    s = cyc;
  endtask

  // One conversion: wait for adc_start, then either answer after dly cycles or stay silent.
  task automatic conv(input logic [11:0] d, input int dly, input bit respond, input bit clr_at_hit,
                      output int s, output logic tv, output logic [11:0] code,
                      output logic op, output logic sh, output logic tmo_pre,
                      output logic tmo, output logic tv_next);
    wait_start(s);
    chk("adc_channel", 32'(adc_channel), 32'(0));
    chk("start_phase", 32'((s - en_cyc) % SD), 32'(0));
    step();
    chk("start_width", 32'(adc_start), 32'(0));
    tv_next = 1'b0;
    if (respond) begin
      repeat (dly - 1) step();
      tmo_pre = adc_timeout;
      adc_valid = 1'b1;
      adc_data  = d;
      step();
      adc_valid = 1'b0;
      adc_data  = 12'($urandom);
      tv = temp_valid; code = temp_code; op = sensor_open; sh = sensor_short; tmo = adc_timeout;
      step();
      tv_next = temp_valid;
    end else begin
      repeat (TO - 1) step();
      tmo_pre = adc_timeout;
      if (clr_at_hit) fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      tv = temp_valid; code = temp_code; op = sensor_open; sh = sensor_short; tmo = adc_timeout;
    end
  endtask

  task automatic check_good(input logic [11:0] d, input int dly, output int s);
    logic tv, op, sh, tp, tm, tvn, etv;
    logic [11:0] code;
    conv(d, dly, 1'b1, 1'b0, s, tv, code, op, sh, tp, tm, tvn);
    model_sample(d, etv);
    chk("temp_valid", 32'(tv), 32'(etv));
    chk("temp_code", 32'(code), 32'(m_code));
    chk("sensor_open", 32'(op), 32'(m_open));
    chk("sensor_short", 32'(sh), 32'(m_short));
    chk("adc_timeout", 32'(tm), 32'(m_tmo));
    chk("temp_valid_width", 32'(tvn), 32'(0));
  endtask

  task automatic clear_timeout();
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    m_tmo = 1'b0;
    chk("tmo_clear", 32'(adc_timeout), 32'(0));
  endtask

  initial begin
    #(100 * 60000);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s1, s2, exp2, n_start, r, dly;
    logic tv, op, sh, tp, tm, tvn, etv;
    logic [11:0] code, d;

    for (int i = 0; i < 8; i++)
      tbl[i] = '{12'h800, (i == 7), (i == 7) ? 12'h800 : 12'h000, 1'b0, 1'b0};
    for (int i = 8; i < 16; i++)
      tbl[i] = '{12'(100 + i - 8), (i == 15), (i == 15) ? 12'd103 : 12'h800, 1'b0, 1'b0};
    tbl[16] = '{12'hFFF, 1'b0, 12'h067, 1'b0, 1'b0};
    tbl[17] = '{12'hFFF, 1'b0, 12'h067, 1'b0, 1'b0};
    tbl[18] = '{12'hFFF, 1'b0, 12'h067, 1'b1, 1'b0};
    tbl[19] = '{12'h400, 1'b0, 12'h067, 1'b0, 1'b0};
    for (int i = 20; i < 27; i++)
      tbl[i] = '{12'h400, (i == 26), (i == 26) ? 12'h400 : 12'h067, 1'b0, 1'b0};
    tbl[27] = '{12'h000, 1'b0, 12'h400, 1'b0, 1'b0};
    tbl[28] = '{12'h00F, 1'b0, 12'h400, 1'b0, 1'b0};
    tbl[29] = '{12'h005, 1'b0, 12'h400, 1'b0, 1'b1};
    tbl[30] = '{12'hFFF, 1'b0, 12'h400, 1'b0, 1'b1};
    tbl[31] = '{12'hFF0, 1'b0, 12'h400, 1'b0, 1'b1};
    tbl[32] = '{12'h010, 1'b0, 12'h400, 1'b0, 1'b0};
    tbl[33] = '{12'hFEF, 1'b0, 12'h400, 1'b0, 1'b0};
    for (int i = 34; i < 40; i++)
      tbl[i] = '{12'h800, (i == 39), (i == 39) ? 12'h7FF : 12'h400, 1'b0, 1'b0};

    rst_n = 1'b0; enable = 1'b0; fault_clr = 1'b0; adc_valid = 1'b0; adc_data = 12'h000;
    model_reset();
    repeat (3) step();
    chk("rst_adc_start", 32'(adc_start), 32'(0));
    chk("rst_temp_code", 32'(temp_code), 32'(0));
    chk("rst_temp_valid", 32'(temp_valid), 32'(0));
    chk("rst_sensor_open", 32'(sensor_open), 32'(0));
    chk("rst_sensor_short", 32'(sensor_short), 32'(0));
    chk("rst_adc_timeout", 32'(adc_timeout), 32'(0));
    rst_n = 1'b1;
    repeat (2) step();

    enable = 1'b1;
    en_cyc = cyc;
    for (int i = 0; i < 40; i++) begin
      conv(tbl[i].d, 170, 1'b1, 1'b0, s, tv, code, op, sh, tp, tm, tvn);
      model_sample(tbl[i].d, etv);
      if (i == 0) chk("first_start", 32'(s - en_cyc), 32'(SD));
      chk("tbl_temp_valid", 32'(tv), 32'(tbl[i].tv));
      chk("tbl_temp_code", 32'(code), 32'(tbl[i].code));
      chk("tbl_sensor_open", 32'(op), 32'(tbl[i].op));
      chk("tbl_sensor_short", 32'(sh), 32'(tbl[i].sh));
      chk("tbl_valid_width", 32'(tvn), 32'(0));
    end

    // Timeout: set on the 400th silent cycle, sticky across the next request, set beats clear.
    conv(12'h000, 0, 1'b0, 1'b0, s1, tv, code, op, sh, tp, tm, tvn);
    chk("tmo_before", 32'(tp), 32'(0));
    chk("tmo_set", 32'(tm), 32'(1));
    chk("tmo_flags_hold", 32'({op, sh}), 32'({m_open, m_short}));
    m_tmo = 1'b1; m_sum = 0; m_n = 0;
    exp2 = s1 + 402;
    while ((exp2 - en_cyc) % SD != 0) exp2++;
    conv(12'h000, 0, 1'b0, 1'b1, s2, tv, code, op, sh, tp, tm, tvn);
    chk("tmo_next_start", 32'(s2), 32'(exp2));
    chk("tmo_sticky", 32'(tp), 32'(1));
    chk("tmo_set_wins", 32'(tm), 32'(1));
    clear_timeout();

    // Disable mid-conversion after four good samples.
    check_good(12'h300, 1, s);
    check_good(12'h310, TO, s);
    check_good(12'h320, 37, s);
    check_good(12'h330, 250, s);
    wait_start(s);
    repeat (10) step();
    enable = 1'b0;
    m_sum = 0; m_n = 0; m_orun = 0; m_srun = 0;
    repeat (3) step();
    adc_valid = 1'b1;
    adc_data  = 12'h800;
    step();
    adc_valid = 1'b0;
    chk("late_valid", 32'(temp_valid), 32'(0));
    chk("late_code_hold", 32'(temp_code), 32'(m_code));
    chk("late_flags_hold", 32'({sensor_open, sensor_short}), 32'({m_open, m_short}));
    n_start = 0;
    for (int k = 0; k < 40; k++) begin
      if (adc_start) n_start++;
      step();
    end
    chk("start_while_off", 32'(n_start), 32'(0));
    enable = 1'b1;
    en_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      check_good(12'h100 + 12'(i * 3), 60 + i, s);
      if (i == 0) chk("restart_delay", 32'(s - en_cyc), 32'(SD));
    end

    for (int i = 0; i < 30; i++) begin
      r   = $urandom_range(0, 99);
      dly = $urandom_range(1, TO);
      if (r < 8) begin
        conv(12'h000, 0, 1'b0, 1'b0, s, tv, code, op, sh, tp, tm, tvn);
        chk("rnd_tmo_pre", 32'(tp), 32'(m_tmo));
        chk("rnd_tmo", 32'(tm), 32'(1));
        m_tmo = 1'b1; m_sum = 0; m_n = 0;
        clear_timeout();
      end else begin
        if (r < 30)      d = 12'hFF0 + 12'($urandom_range(0, 15));
        else if (r < 52) d = 12'($urandom_range(0, 15));
        else             d = 12'($urandom_range(16, 4079));
        check_good(d, dly, s);
      end
    end

    // Asynchronous reset while a conversion is outstanding.
    wait_start(s);
    repeat (5) step();
    #10 rst_n = 1'b0;
    #1;
    chk("arst_adc_start", 32'(adc_start), 32'(0));
    chk("arst_temp_code", 32'(temp_code), 32'(0));
    chk("arst_temp_valid", 32'(temp_valid), 32'(0));
    chk("arst_flags", 32'({sensor_open, sensor_short, adc_timeout}), 32'(0));
    enable = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
    step();
    enable = 1'b1;
    en_cyc = cyc;
    check_good(12'h555, 50, s);
    chk("reset_restart", 32'(s - en_cyc), 32'(SD));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
